// File: rtl/top_nco_cnt_disp.sv
// Seconds counter (00..59) driven by an NCO tick, shown on the two rightmost
// digits of a six-digit multiplexed seven-segment display; other digits blank.
module top_nco_cnt_disp #(
  parameter logic [31:0] NCO_NUM  = 32'd50_000_000,
  parameter logic [31:0] SCAN_NUM = 32'd50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] o_seg_enb,
  output logic       o_seg_dp,
  output logic [6:0] o_seg
);

  localparam logic [2:0] LAST_DIG = 3'd5;

  logic [31:0] nco_cnt;
  logic        tick;
  logic [3:0]  sec_ones;
  logic [3:0]  sec_tens;
  logic [31:0] scan_cnt;
  logic        scan_step;
  logic [2:0]  dig;

  // Segment pattern a..g (bit6..bit0); anything outside 0..9 is blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'b1111110;
      4'd1:    bcd_to_seg = 7'b0110000;
      4'd2:    bcd_to_seg = 7'b1101101;
      4'd3:    bcd_to_seg = 7'b1111001;
      4'd4:    bcd_to_seg = 7'b0110011;
      4'd5:    bcd_to_seg = 7'b1011011;
      4'd6:    bcd_to_seg = 7'b1011111;
      4'd7:    bcd_to_seg = 7'b1110000;
      4'd8:    bcd_to_seg = 7'b1111111;
      4'd9:    bcd_to_seg = 7'b1111011;
      default: bcd_to_seg = 7'b0000000;
    endcase
  endfunction

  assign tick = (nco_cnt == NCO_NUM - 32'd1);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nco_cnt <= '0;
    end else if (tick) begin
      nco_cnt <= '0;
    end else begin
      nco_cnt <= nco_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_ones <= '0;
      sec_tens <= '0;
    end else if (tick) begin
      if (sec_ones < 4'd9) begin
        sec_ones <= sec_ones + 4'd1;
      end else begin
        sec_ones <= '0;
        sec_tens <= (sec_tens < 4'd5) ? sec_tens + 4'd1 : 4'd0;
      end
    end
  end

  assign scan_step = (scan_cnt == SCAN_NUM - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_step) begin
      scan_cnt <= '0;
      dig      <= (dig == LAST_DIG) ? 3'd0 : dig + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 32'd1;
    end
  end

  assign o_seg_enb = ~(6'b000001 << dig);
  assign o_seg_dp  = 1'b0;

  always_comb begin
    // NOTE: default assigned first so no path leaves o_seg unassigned,
    // which would otherwise infer a latch.
    o_seg = 7'b0000000;
    case (dig)
      3'd0:    o_seg = bcd_to_seg(sec_ones);
      3'd1:    o_seg = bcd_to_seg(sec_tens);
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

// File: tb/tb_top_nco_cnt_disp.sv
// Scoreboard bench: stimulus queues cycle-tagged expected display frames,
// a monitor pops and compares the frames on the falling clock edge.
module tb_top_nco_cnt_disp;

  typedef struct {
    int unsigned cyc;
    logic [5:0]  enb;
    logic [6:0]  seg;
    logic        dp;
    string       tag;
  } exp_t;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  localparam logic [5:0] ENB_TAB [6] = '{
    6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

  logic       clk;
  logic       rst_n;
  logic [5:0] o_seg_enb;
  logic       o_seg_dp;
  logic [6:0] o_seg;

  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  top_nco_cnt_disp #(.NCO_NUM(32'd10), .SCAN_NUM(32'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .o_seg_enb (o_seg_enb),
    .o_seg_dp  (o_seg_dp),
    .o_seg     (o_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got enb=%b seg=%b dp=%b, expected enb=%b seg=%b dp=%b",
               name, act[13:8], act[7:1], act[0], req[13:8], req[7:1], req[0]);
    end else begin
      n_pass++;
    end
  endtask

  // Display j cycles after reset release with NCO_NUM=10, SCAN_NUM=4:
  // digit = (j/4) mod 6, count = (j/10) mod 60.
  function automatic exp_t model(input int unsigned c, input int unsigned j, input string ph);
    exp_t        e;
    int unsigned d;
    int unsigned cnt;
    d     = (j / 4) % 6;
    cnt   = (j / 10) % 60;
    e.cyc = c;
    e.enb = ENB_TAB[d];
    e.seg = 7'b0000000;
    if (d == 0) e.seg = SEG_TAB[cnt % 10];
    if (d == 1) e.seg = SEG_TAB[cnt / 10];
    e.dp  = 1'b0;
    e.tag = $sformatf("%s_j%0d_cnt%0d_dig%0d", ph, j, cnt, d);
    return e;
  endfunction

  // Monitor: compares every queued frame whose cycle tag has been reached.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, {o_seg_enb, o_seg, o_seg_dp}, {mon_e.enb, mon_e.seg, mon_e.dp});
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  int unsigned base;

  initial begin
    rst_n = 1'b0;
    wait_edge();
    for (int k = 0; k < 3; k++) exp_q.push_back(model(cyc + k, 0, "rst"));
    repeat (3) wait_edge();

    // Phase A: count from 00 up to 25, then reset mid-run.
    base  = cyc;
    rst_n = 1'b1;
    for (int j = 0; j < 253; j++) exp_q.push_back(model(base + j, j, "runA"));
    repeat (253) wait_edge();

    for (int k = 0; k < 3; k++) exp_q.push_back(model(cyc + k, 0, "midrst"));
    rst_n = 1'b0;
    repeat (3) wait_edge();

    // Phase B: restart from 00, through 37 and 59, wrapping to 00.
    base  = cyc;
    rst_n = 1'b1;
    for (int j = 0; j <= 620; j++) exp_q.push_back(model(base + j, j, "runB"));
    repeat (621) wait_edge();
    @(negedge clk);
    #1;

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d frames left unchecked, expected 0", exp_q.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
